// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Central stall/flush controller for the 5-stage pipeline. Detects read-after-
// write hazards between the D-stage sources and the E/M-stage destinations
// using the T_use/T_new scheme, sequences the multi-cycle mult/div unit, and
// keeps a saturating count of stalled cycles.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_A3,
  input  logic             E_RegWrite,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_A3,
  input  logic             M_RegWrite,
  input  logic [1:0]       M_Tnew,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  output logic             stall,
  output logic             PC_en,
  output logic             D_en,
  output logic             E_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  // Busy-count load values, narrowed to the 4-bit counter width.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // One source-vs-destination hazard term. A source that is $0, or that the
  // D instruction never reads (T_use==3), cannot stall. A producer with
  // T_new <= T_use is covered by forwarding, so only T_new > T_use stalls.
  function automatic logic reg_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] dst,
    input logic       we,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && (tuse != 2'd3) && we && (dst == src) && (tnew > tuse);
  endfunction

  logic       stall_rs_e_s;
  logic       stall_rs_m_s;
  logic       stall_rt_e_s;
  logic       stall_rt_m_s;
  logic       stall_md_s;
  logic       stall_s;
  logic [3:0] md_cnt_r;
  logic [3:0] md_cnt_nxt_s;
  logic       md_busy_r;
  logic       md_done_r;
  logic [CNT_W-1:0] stall_cnt_r;

  // Hazard detection: four register terms plus the mult/div structural term.
  always_comb begin
    stall_rs_e_s = reg_hazard(D_rs, D_Tuse_rs, E_A3, E_RegWrite, E_Tnew);
    stall_rs_m_s = reg_hazard(D_rs, D_Tuse_rs, M_A3, M_RegWrite, M_Tnew);
    stall_rt_e_s = reg_hazard(D_rt, D_Tuse_rt, E_A3, E_RegWrite, E_Tnew);
    stall_rt_m_s = reg_hazard(D_rt, D_Tuse_rt, M_A3, M_RegWrite, M_Tnew);
    // A HI/LO access in D must wait while the unit is busy or being started.
    stall_md_s   = D_is_md & (md_busy_r | E_md_start);
    stall_s      = stall_rs_e_s | stall_rs_m_s | stall_rt_e_s | stall_rt_m_s | stall_md_s;
  end

  // Next busy count: a running count always decrements; a start is only
  // accepted when the unit is idle, otherwise it is silently dropped.
  always_comb begin
    md_cnt_nxt_s = md_cnt_r;
    if (md_cnt_r != 4'd0) begin
      md_cnt_nxt_s = md_cnt_r - 4'd1;
    end else if (E_md_start) begin
      md_cnt_nxt_s = E_md_is_div ? DIV_LOAD : MULT_LOAD;
    end else begin
      md_cnt_nxt_s = 4'd0;
    end
  end

  // Mult/div sequencer state; reset abandons any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_r  <= 4'd0;
      md_busy_r <= 1'b0;
      md_done_r <= 1'b0;
    end else begin
      md_cnt_r  <= md_cnt_nxt_s;
      md_busy_r <= (md_cnt_nxt_s != 4'd0);
      // A count of 1 always moves to 0 on this edge, so done follows it.
      md_done_r <= (md_cnt_r == 4'd1);
    end
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Pipeline controls act in the same cycle the hazard is seen.
  assign stall     = stall_s;
  assign PC_en     = ~stall_s;
  assign D_en      = ~stall_s;
  assign E_flush   = stall_s;
  assign md_busy   = md_busy_r;
  assign md_done   = md_done_r;
  assign stall_cnt = stall_cnt_r;

endmodule
